// File: rtl/run_mon_pkg.sv
// Shared types for the run-control monitor: termination causes and FSM states.
package run_mon_pkg;

    localparam int CAUSE_W = 3;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_HALT     = 3'd1,
        CAUSE_TIMEOUT  = 3'd2,
        CAUSE_DEADLOCK = 3'd3,
        CAUSE_ERROR    = 3'd4
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/run_control_monitor_if.sv
// Bench-facing bundle of the run-control monitor: run inputs from the bench,
// verdict and counters back to the bench's end-of-test report.
interface run_control_monitor_if #(
    parameter int NUM_COMMIT = 2,
    parameter int CNT_W      = 32,
    parameter int ERRCODE_W  = 16
);
    import run_mon_pkg::*;

    logic                  enable;
    logic [CNT_W-1:0]      timeout_limit;
    logic [NUM_COMMIT-1:0] commit;
    logic [NUM_COMMIT-1:0] halt;
    logic [ERRCODE_W-1:0]  errcode;

    logic                  done;
    cause_t                cause;
    logic [ERRCODE_W-1:0]  err_latched;
    logic [CNT_W-1:0]      cycle_count;
    logic [63:0]           commit_count;

    modport master (
        output enable, timeout_limit, commit, halt, errcode,
        input  done, cause, err_latched, cycle_count, commit_count
    );

    modport slave (
        input  enable, timeout_limit, commit, halt, errcode,
        output done, cause, err_latched, cycle_count, commit_count
    );

endinterface

// File: rtl/commit_popcount.sv
// Counts how many retire lanes committed this cycle (0..NUM_COMMIT).
module commit_popcount #(
    parameter int  NUM_COMMIT = 2,
    localparam int COUNT_W    = $clog2(NUM_COMMIT + 1)
) (
    input  logic [NUM_COMMIT-1:0] lanes,
    output logic [COUNT_W-1:0]    count
);

    // Sum the valid bits of all lanes.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_COMMIT; i++) begin
            count = count + COUNT_W'(lanes[i]);
        end
    end

endmodule

// File: rtl/run_control_monitor.sv
// Run-control monitor: decides when a CPU bench run ends and why
// (halt, timeout, commit-starvation deadlock, or checker error after a drain).
// Optional feature macro: RUN_MON_DEADLOCK_EN compiles in the idle counter
// and the DEADLOCK cause; without it DEADLOCK_CYCLES has no effect.
module run_control_monitor
    import run_mon_pkg::*;
#(
    parameter int NUM_COMMIT      = 2,
    parameter int CNT_W           = 32,
    parameter int ERRCODE_W       = 16,
    parameter int ERR_DRAIN       = 5,
    parameter int DEADLOCK_CYCLES = 10000
) (
    input logic                clk,
    input logic                rst,
    run_control_monitor_if.slave bus
);

    localparam int PC_W    = $clog2(NUM_COMMIT + 1);
    localparam int DRAIN_W = (ERR_DRAIN > 1) ? $clog2(ERR_DRAIN) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ERR_DRAIN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    state_t               state;
    logic [PC_W-1:0]      commit_pc;
    logic [DRAIN_W-1:0]   drain_count;
    logic [ERRCODE_W-1:0] errcode_in;
    logic [CNT_W-1:0]     cycle_next;
    logic                 any_commit;
    logic                 halt_hit;
    logic                 error_hit;
    logic                 timeout_hit;
    logic                 deadlock_hit;

    commit_popcount #(
        .NUM_COMMIT(NUM_COMMIT)
    ) u_commit_popcount (
        .lanes(bus.commit),
        .count(commit_pc)
    );

    assign errcode_in  = bus.errcode;
    assign any_commit  = |bus.commit;
    assign halt_hit    = |(bus.commit & bus.halt);
    assign error_hit   = (errcode_in != '0);
    assign timeout_hit = (bus.timeout_limit != '0) &&
                         (bus.cycle_count == bus.timeout_limit - CNT_W'(1));
    assign cycle_next  = (bus.cycle_count == CNT_MAX) ? bus.cycle_count
                                                      : bus.cycle_count + CNT_W'(1);

`ifdef RUN_MON_DEADLOCK_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(DEADLOCK_CYCLES - 1);

    logic [CNT_W-1:0] idle_count;

    // Length of the current commit-free streak while the run is live.
    always_ff @(posedge clk) begin
        if (!rst || state == ST_IDLE) begin
            idle_count <= '0;
        end else if (state == ST_RUN || state == ST_DRAIN) begin
            if (any_commit) begin
                idle_count <= '0;
            end else if (idle_count != CNT_MAX) begin
                idle_count <= idle_count + CNT_W'(1);
            end
        end
    end

    assign deadlock_hit = (DEADLOCK_CYCLES != 0) && !any_commit && (idle_count == IDLE_LAST);
`else
    // Deadlock detection is compiled out: constant zero for any legal DEADLOCK_CYCLES.
    assign deadlock_hit = (DEADLOCK_CYCLES < 0);
`endif

    // Run-control FSM with its counters and registered verdict outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= ST_IDLE;
            drain_count      <= '0;
            bus.done         <= 1'b0;
            bus.cause        <= CAUSE_NONE;
            bus.err_latched  <= '0;
            bus.cycle_count  <= '0;
            bus.commit_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drain_count      <= '0;
                    bus.cycle_count  <= '0;
                    bus.commit_count <= '0;
                    if (bus.enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    bus.cycle_count  <= cycle_next;
                    bus.commit_count <= bus.commit_count + 64'(commit_pc);
                    if (error_hit) begin
                        bus.err_latched <= errcode_in;
                        drain_count     <= '0;
                        state           <= ST_DRAIN;
                    end else if (halt_hit) begin
                        state     <= ST_DONE;
                        bus.done  <= 1'b1;
                        bus.cause <= CAUSE_HALT;
                    end else if (deadlock_hit) begin
                        state     <= ST_DONE;
                        bus.done  <= 1'b1;
                        bus.cause <= CAUSE_DEADLOCK;
                    end else if (timeout_hit) begin
                        state     <= ST_DONE;
                        bus.done  <= 1'b1;
                        bus.cause <= CAUSE_TIMEOUT;
                    end
                end
                ST_DRAIN: begin
                    bus.cycle_count  <= cycle_next;
                    bus.commit_count <= bus.commit_count + 64'(commit_pc);
                    if (drain_count == DRAIN_LAST) begin
                        state     <= ST_DONE;
                        bus.done  <= 1'b1;
                        bus.cause <= CAUSE_ERROR;
                    end else begin
                        drain_count <= drain_count + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_control_monitor.sv
// Self-checking bench for run_control_monitor: directed scenarios from the
// test plan plus randomized runs, all checked against a behavioural model.
module tb_run_control_monitor;
    import run_mon_pkg::*;

    localparam int NUM_COMMIT      = 2;
    localparam int CNT_W           = 32;
    localparam int ERRCODE_W       = 16;
    localparam int ERR_DRAIN       = 5;
    localparam int DEADLOCK_CYCLES = 50;
`ifdef RUN_MON_DEADLOCK_EN
    localparam bit DL_ON = 1'b1;
`else
    localparam bit DL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    run_control_monitor_if #(
        .NUM_COMMIT(NUM_COMMIT), .CNT_W(CNT_W), .ERRCODE_W(ERRCODE_W)
    ) bus ();

    run_control_monitor #(
        .NUM_COMMIT(NUM_COMMIT), .CNT_W(CNT_W), .ERRCODE_W(ERRCODE_W),
        .ERR_DRAIN(ERR_DRAIN), .DEADLOCK_CYCLES(DEADLOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running bench clock.
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state: what the bench expects to see after each edge.
    bit              m_started;
    bit              m_done;
    int              m_drain_left;
    int              m_quiet;
    longint unsigned m_cycles;
    longint unsigned m_commits;
    int unsigned     m_cause;
    int unsigned     m_err;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelFinish(input int unsigned why);
        m_done  = 1'b1;
        m_cause = why;
    endfunction

    // Advance the reference by one clock using the rules of the run monitor.
    function automatic void modelStep(input bit rst_n, input bit en, input logic [31:0] tl,
                                      input logic [1:0] cm, input logic [1:0] ht, input logic [15:0] ec);
        longint unsigned prior;
        int n;
        if (!rst_n) begin
            m_started = 0; m_done = 0; m_drain_left = 0; m_quiet = 0;
            m_cycles = 0; m_commits = 0; m_cause = 0; m_err = 0;
            return;
        end
        if (m_done) return;
        if (!m_started) begin
            if (en) m_started = 1;
            return;
        end
        n     = $countones(cm);
        prior = m_cycles;
        if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
        m_commits = m_commits + longint'(n);
        m_quiet   = (n == 0) ? m_quiet + 1 : 0;
        if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) modelFinish(4);
            return;
        end
        if (ec != 0) begin
            m_err        = ec;
            m_drain_left = ERR_DRAIN;
        end else if ((cm & ht) != 0) begin
            modelFinish(1);
        end else if (DL_ON && DEADLOCK_CYCLES > 0 && m_quiet == DEADLOCK_CYCLES) begin
            modelFinish(3);
        end else if (tl != 0 && prior + 1 == longint'(tl)) begin
            modelFinish(2);
        end
    endfunction

    // Drive one cycle of inputs, clock it, and compare every output to the model.
    task automatic applyStimulus(input bit rst_n, input bit en, input logic [31:0] tl,
                                 input logic [1:0] cm, input logic [1:0] ht, input logic [15:0] ec);
        rst               = rst_n;
        bus.enable        = en;
        bus.timeout_limit = tl;
        bus.commit        = cm;
        bus.halt          = ht;
        bus.errcode       = ec;
        modelStep(rst_n, en, tl, cm, ht, ec);
        @(posedge clk);
        #1;
        checkOutput("done",         64'(bus.done),         64'(m_done));
        checkOutput("cause",        64'(bus.cause),        64'(m_cause));
        checkOutput("err_latched",  64'(bus.err_latched),  64'(m_err));
        checkOutput("cycle_count",  64'(bus.cycle_count),  m_cycles);
        checkOutput("commit_count", bus.commit_count,      m_commits);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus(0, 1, 0, 2'b11, 2'b11, 16'h1);
    endtask

    initial begin
        logic [31:0] tl;
        int          quiet_from;

        // Reset state with busy inputs.
        doReset();
        checkOutput("reset_done", 64'(bus.done), 64'd0);

        // Basic halt: 10 cycles of double commits, then lane 1 halts.
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 2'b11, 2'b00, 0);
        applyStimulus(1, 0, 0, 2'b11, 2'b10, 0);
        checkOutput("halt_done",    64'(bus.done),        64'd1);
        checkOutput("halt_cause",   64'(bus.cause),       64'd1);
        checkOutput("halt_commits", bus.commit_count,     64'd22);
        checkOutput("halt_cycles",  64'(bus.cycle_count), 64'd11);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 7, 2'b11, 2'b11, 16'h5);

        // Timeout after exactly 100 RUN cycles.
        doReset();
        applyStimulus(1, 1, 100, 2'b00, 2'b00, 0);
        for (int i = 0; i < 100; i++) applyStimulus(1, 0, 100, 2'b11, 2'b00, 0);
        checkOutput("tmo_done",   64'(bus.done),        64'd1);
        checkOutput("tmo_cause",  64'(bus.cause),       64'd2);
        checkOutput("tmo_cycles", 64'(bus.cycle_count), 64'd100);

        // Timeout disabled: 1000 busy cycles never finish.
        doReset();
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 1000; i++) applyStimulus(1, 0, 0, 2'b11, 2'b00, 0);
        checkOutput("notmo_done", 64'(bus.done), 64'd0);

        // Deadlock: commits stop from RUN cycle 20.
        doReset();
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 80; c++) begin
            applyStimulus(1, 0, 0, (c < 20) ? 2'b01 : 2'b00, 2'b00, 0);
            if (c == 68) checkOutput("dl_early", 64'(bus.done), 64'd0);
            if (c == 69) checkOutput("dl_done",  64'(bus.done), 64'(DL_ON));
        end
        checkOutput("dl_cause", 64'(bus.cause), DL_ON ? 64'd3 : 64'd0);

        // Error drain: errcode 7 then 9, a halt during drain is ignored.
        doReset();
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 40; c++) begin
            applyStimulus(1, 0, 0, 2'b11, (c == 32) ? 2'b11 : 2'b00,
                          (c < 30) ? 16'h0 : ((c == 30) ? 16'h0007 : 16'h0009));
            if (c == 34) checkOutput("err_early", 64'(bus.done), 64'd0);
            if (c == 35) checkOutput("err_done",  64'(bus.done), 64'd1);
        end
        checkOutput("err_cause",   64'(bus.cause),       64'd4);
        checkOutput("err_latched", 64'(bus.err_latched), 64'h7);

        // Halt together with timeout expiry reports HALT.
        doReset();
        applyStimulus(1, 1, 5, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 5; c++) applyStimulus(1, 0, 5, 2'b01, (c == 5) ? 2'b01 : 2'b00, 0);
        checkOutput("simul_cause", 64'(bus.cause), 64'd1);

        // Halt without its lane's commit is ignored; run ends on timeout.
        doReset();
        applyStimulus(1, 1, 8, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 10; c++) applyStimulus(1, 0, 8, (c % 2) ? 2'b01 : 2'b00, 2'b10, 0);
        checkOutput("nohalt_cause", 64'(bus.cause), 64'd2);

        // Reset while draining, then a normal run.
        doReset();
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 3; c++) applyStimulus(1, 0, 0, 2'b11, 2'b00, 0);
        applyStimulus(1, 0, 0, 2'b01, 2'b00, 16'h5);
        applyStimulus(1, 0, 0, 2'b01, 2'b00, 0);
        applyStimulus(1, 0, 0, 2'b01, 2'b00, 0);
        applyStimulus(0, 0, 0, 2'b11, 2'b00, 0);
        checkOutput("midrst_err", 64'(bus.err_latched), 64'd0);
        applyStimulus(1, 1, 0, 2'b00, 2'b00, 0);
        for (int c = 1; c <= 3; c++) applyStimulus(1, 0, 0, 2'b10, 2'b00, 0);
        applyStimulus(1, 0, 0, 2'b01, 2'b01, 0);
        checkOutput("midrst_cause",   64'(bus.cause),    64'd1);
        checkOutput("midrst_commits", bus.commit_count,  64'd4);

        // Randomized runs with occasional halts, errors, quiet stretches and resets.
        for (int run = 0; run < 30; run++) begin
            doReset();
            tl         = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(10, 150));
            quiet_from = $urandom_range(5, 120);
            for (int c = 0; c < 250; c++) begin
                applyStimulus(($urandom_range(0, 299) != 0),
                              1'($urandom),
                              tl,
                              (c >= quiet_from && c < quiet_from + 70) ? 2'b00 : 2'($urandom),
                              ($urandom_range(0, 60) == 0) ? 2'($urandom) : 2'b00,
                              ($urandom_range(0, 100) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
